// File: rtl/mem_pkg.sv
// Shared memory-subsystem types: line geometry, FSM state encoding and operation encoding.
package mem_pkg;

    localparam int unsigned LINE_ADDR_W = 14;
    localparam int unsigned LINE_DATA_W = 64;
    localparam int unsigned WORD_W      = 16;
    localparam int unsigned LAT_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } mem_op_t;

endpackage

// File: rtl/line_mem_lat_ctr.sv
// Loadable down-counter with a registered "last" flag that is high while the count equals 1.
module line_mem_lat_ctr #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q;

    // Load has priority over decrement; the count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= (cnt_d == CNT_W'(1));
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/line_mem.sv
// Line-wide backing memory with fixed access latency and a one-cycle completion pulse.
// Optional macro LINE_MEM_PROTO_CHK_EN enables the sticky requester-protocol checker.
module line_mem
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = LINE_ADDR_W,
    parameter int unsigned DATA_W  = LINE_DATA_W,
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    output logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_rdy,
    output logic              proto_err
);

    localparam int unsigned          DEPTH    = 2 ** ADDR_W;
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 1);

    mem_state_t        state_q, state_d;
    mem_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rdy_q, rdy_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ctr_load, ctr_dec, ctr_last, wr_en;

    logic [DATA_W-1:0] mem_q [DEPTH];

    line_mem_lat_ctr #(
        .CNT_W (LAT_CNT_W)
    ) u_lat_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ctr_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (ctr_dec),
        .last_o     (ctr_last)
    );

    // Next-state and registered-output logic; write wins when both requests are high.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        ctr_load  = 1'b0;
        ctr_dec   = 1'b0;
        wr_en     = 1'b0;
        rdy_d     = 1'b0;
        rd_data_d = rd_data_q;

        unique case (state_q)
            IDLE: begin
                if (mem_re || mem_we) begin
                    addr_d   = mem_addr;
                    op_d     = mem_we ? OP_WR : OP_RD;
                    wr_en    = mem_we;
                    ctr_load = 1'b1;
                    state_d  = (LATENCY > 1) ? BUSY : RESP;
                end
            end
            BUSY: begin
                ctr_dec = 1'b1;
                if (ctr_last) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // RESP is only ever entered from IDLE or BUSY, so this fires once per request.
        if (state_d == RESP) begin
            rdy_d = 1'b1;
            if (op_d == OP_RD) begin
                rd_data_d = mem_q[addr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_RD;
            addr_q    <= '0;
            rdy_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            rdy_q     <= rdy_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Array contents survive reset; writes commit at the accept edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[mem_addr] <= mem_wr_data;
        end
    end

    assign mem_rdy     = rdy_q;
    assign mem_rd_data = rd_data_q;

`ifdef LINE_MEM_PROTO_CHK_EN
    logic re_prev_q, we_prev_q, proto_err_q;
    logic viol_both_c, viol_chg_c, viol_drop_c;

    assign viol_both_c = mem_re && mem_we;
    assign viol_chg_c  = (state_q == BUSY) &&
                         ((mem_addr != addr_q) || (mem_re != re_prev_q) || (mem_we != we_prev_q));
    assign viol_drop_c = (state_q == BUSY) && !(mem_re || mem_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_prev_q   <= 1'b0;
            we_prev_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            re_prev_q   <= mem_re;
            we_prev_q   <= mem_we;
            proto_err_q <= proto_err_q || viol_both_c || viol_chg_c || viol_drop_c;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            if (viol_both_c) $display("%0t line_mem proto: re and we both high", $time);
            if (viol_chg_c)  $display("%0t line_mem proto: request changed while busy", $time);
            if (viol_drop_c) $display("%0t line_mem proto: request dropped while busy", $time);
        end
    end
`endif

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_line_mem.sv
// Directed bench for line_mem: three instances (latency 4, 1, 15) driven from a vector table
// plus hand sequences for back-to-back requests, mid-operation reset and protocol flagging.
module tb_line_mem;
    import mem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        re     [3];
    logic        we     [3];
    logic [13:0] addr   [3];
    logic [63:0] wdat   [3];
    logic [63:0] rd     [3];
    logic        rdy    [3];
    logic        perr   [3];

    int n_chk;
    int n_err;

    line_mem #(.ADDR_W(14), .DATA_W(64), .LATENCY(4)) u_d0 (
        .clk(clk), .rst_n(rst_n), .mem_re(re[0]), .mem_we(we[0]), .mem_addr(addr[0]),
        .mem_wr_data(wdat[0]), .mem_rd_data(rd[0]), .mem_rdy(rdy[0]), .proto_err(perr[0]));

    line_mem #(.ADDR_W(14), .DATA_W(64), .LATENCY(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .mem_re(re[1]), .mem_we(we[1]), .mem_addr(addr[1]),
        .mem_wr_data(wdat[1]), .mem_rd_data(rd[1]), .mem_rdy(rdy[1]), .proto_err(perr[1]));

    line_mem #(.ADDR_W(14), .DATA_W(64), .LATENCY(15)) u_d2 (
        .clk(clk), .rst_n(rst_n), .mem_re(re[2]), .mem_we(we[2]), .mem_addr(addr[2]),
        .mem_wr_data(wdat[2]), .mem_rd_data(rd[2]), .mem_rdy(rdy[2]), .proto_err(perr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          d;
        logic        w;
        logic        b;
        logic [13:0] a;
        logic [63:0] wd;
        logic [63:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 15);
    endfunction

    // One request held until rdy; checks rdy cycle, data at rdy, and single-cycle pulse.
    task automatic do_req(input int d, input logic w, input logic b, input logic [13:0] a,
                          input logic [63:0] wd, input logic [63:0] exp);
        int          seen;
        int          lat;
        logic [63:0] got;
        seen = -1;
        got  = '0;
        lat  = lat_of(d);
        @(posedge clk); #1;
        re[d]   = !w || b;
        we[d]   = w || b;
        addr[d] = a;
        wdat[d] = wd;
        for (int c = 0; c <= lat + 1; c++) begin
            @(negedge clk);
            if (rdy[d] && seen < 0) begin
                seen = c;
                got  = rd[d];
            end
            if (seen >= 0) break;
        end
        check($sformatf("rdy_cycle d%0d a=%h", d, a), 64'(seen), 64'(lat));
        check($sformatf("rd_data d%0d a=%h", d, a), got, exp);
        @(posedge clk); #1;
        re[d] = 1'b0;
        we[d] = 1'b0;
        @(negedge clk);
        check($sformatf("rdy_pulse_width d%0d", d), 64'(rdy[d]), 64'd0);
    endtask

    vec_t vecs [14];
    logic exp_perr;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            re[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdat[i] = '0;
        end
`ifdef LINE_MEM_PROTO_CHK_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif

        vecs[0]  = '{0, 1'b1, 1'b0, 14'h0010, 64'h1111_2222_3333_4444, 64'h0};
        vecs[1]  = '{0, 1'b0, 1'b0, 14'h0010, 64'h0, 64'h1111_2222_3333_4444};
        vecs[2]  = '{1, 1'b1, 1'b0, 14'h3FFF, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0};
        vecs[3]  = '{1, 1'b0, 1'b0, 14'h3FFF, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5};
        vecs[4]  = '{2, 1'b1, 1'b0, 14'h3FFF, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0};
        vecs[5]  = '{2, 1'b0, 1'b0, 14'h3FFF, 64'h0, 64'h5A5A_5A5A_5A5A_5A5A};
        vecs[6]  = '{0, 1'b1, 1'b0, 14'h0C0D, 64'hDEAD_BEEF_0000_FFFF, 64'h1111_2222_3333_4444};
        vecs[7]  = '{0, 1'b1, 1'b0, 14'h0A0B, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444};
        vecs[8]  = '{0, 1'b0, 1'b0, 14'h0C0D, 64'h0, 64'hDEAD_BEEF_0000_FFFF};
        vecs[9]  = '{0, 1'b0, 1'b0, 14'h0A0B, 64'h0, 64'h0123_4567_89AB_CDEF};
        vecs[10] = '{0, 1'b1, 1'b0, 14'h0001, 64'hCAFE_0000_CAFE_0001, 64'h0123_4567_89AB_CDEF};
        vecs[11] = '{0, 1'b1, 1'b1, 14'h0300, 64'h7777_8888_9999_0000, 64'h0123_4567_89AB_CDEF};
        vecs[12] = '{0, 1'b0, 1'b0, 14'h0300, 64'h0, 64'h7777_8888_9999_0000};
        vecs[13] = '{0, 1'b1, 1'b0, 14'h0200, 64'hFEED_FACE_0BAD_F00D, 64'h7777_8888_9999_0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset rdy", 64'(rdy[0]), 64'd0);
        check("reset rd_data", rd[0], 64'h0);
        check("reset proto_err", 64'(perr[0]), 64'd0);
        check("reset state", 64'(u_d0.state_q), 64'(IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_req(vecs[i].d, vecs[i].w, vecs[i].b, vecs[i].a, vecs[i].wd, vecs[i].exp);
        end

        check("proto_err d0 after re&we", 64'(perr[0]), 64'(exp_perr));
        check("proto_err d1 clean", 64'(perr[1]), 64'd0);

        // Back-to-back reads with re held high straight through the first rdy.
        @(posedge clk); #1;
        re[0] = 1'b1; we[0] = 1'b0; addr[0] = 14'h0001;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("b2b rdy c%0d", c), 64'(rdy[0]), 64'((c == 4) || (c == 9)));
            if (rdy[0]) check($sformatf("b2b rd_data c%0d", c), rd[0], 64'hCAFE_0000_CAFE_0001);
        end
        @(posedge clk); #1;
        re[0] = 1'b0;
        @(negedge clk);
        check("b2b rdy after", 64'(rdy[0]), 64'd0);

        // Reset asserted in cycle 2 of a read: pending read is discarded.
        @(posedge clk); #1;
        re[0] = 1'b1; addr[0] = 14'h0200;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("rst_abort rdy c%0d", c), 64'(rdy[0]), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        re[0] = 1'b0;
        @(negedge clk);
        check("rst_abort state", 64'(u_d0.state_q), 64'(IDLE));
        check("rst_abort proto_err cleared", 64'(perr[0]), 64'd0);
        check("rst_abort rd_data cleared", rd[0], 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rst_abort no rdy c%0d", c), 64'(rdy[0]), 64'd0);
        end
        do_req(0, 1'b0, 1'b0, 14'h0200, 64'h0, 64'hFEED_FACE_0BAD_F00D);
        do_req(1, 1'b0, 1'b0, 14'h3FFF, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
